// File: rtl/issue_buf.sv
// Issue buffer: out-of-order slot array, lowest free slot on accept, lowest occupied slot issues.
// Latency: 1 cycle accept-to-out_valid (2 with ISSUE_BUF_OUTREG_EN output register).
// Backpressure: in_ready drops when full or flushing; out_* hold while out_valid && !out_ready.
module issue_buf #(
    parameter int DATA  = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA-1:0]            in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA-1:0]            out_data,
    output logic [$clog2(DEPTH)-1:0]   out_idx,
    output logic [DEPTH-1:0]           occ_vec,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA-1:0]  slot_data [DEPTH];
    logic [DEPTH-1:0] occ;
    logic [CW-1:0]    cnt;

    logic             cand_vld;
    logic [IW-1:0]    cand_idx;
    logic [IW-1:0]    free_idx;
    logic             accept;
    logic             slot_clr;
    logic             dec;
    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] set_mask;

    // Both selectors look at pre-edge occupancy, so a slot freed this edge is not refilled.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (occ[i]) begin
                cand_vld = 1'b1;
                cand_idx = IW'(i);
            end
            if (!occ[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign in_ready = !reset && (cnt < CW'(DEPTH)) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef ISSUE_BUF_OUTREG_EN
    logic            reg_vld;
    logic [DATA-1:0] reg_data;
    logic [IW-1:0]   reg_idx;
    logic            consume;

    assign consume  = reg_vld && out_ready && !flush;
    assign slot_clr = cand_vld && (!reg_vld || out_ready) && !flush;
    assign dec      = consume;

    assign out_valid = reg_vld;
    assign out_data  = reg_vld ? reg_data : '0;
    assign out_idx   = reg_vld ? reg_idx  : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_vld  <= 1'b0;
            reg_data <= '0;
            reg_idx  <= '0;
        end else if (flush) begin
            reg_vld  <= 1'b0;
            reg_data <= '0;
            reg_idx  <= '0;
        end else if (slot_clr) begin
            reg_vld  <= 1'b1;
            reg_data <= slot_data[cand_idx];
            reg_idx  <= cand_idx;
        end else if (consume) begin
            reg_vld  <= 1'b0;
        end
    end
`else
    assign slot_clr = cand_vld && out_ready && !flush;
    assign dec      = slot_clr;

    assign out_valid = cand_vld;
    assign out_data  = cand_vld ? slot_data[cand_idx] : '0;
    assign out_idx   = cand_vld ? cand_idx : '0;
`endif

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (slot_clr) clr_mask[cand_idx] = 1'b1;
        if (accept)   set_mask[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ <= '0;
            cnt <= '0;
        end else if (flush) begin
            occ <= '0;
            cnt <= '0;
        end else begin
            occ <= (occ & ~clr_mask) | set_mask;
            case ({accept, dec})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_data[free_idx] <= in_data;
        end
    end

    assign occ_vec = occ;
    assign count   = cnt;

endmodule

// File: doc/issue_buf.md
ISSUE_BUF -- requirements
Module: issue_buf

Interface
REQ-001 SHALL have parameter DATA, default 8: width of one entry payload in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of entry slots, legal range 2..64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream offers in_data this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, DATA bits: incoming payload.
REQ-008 SHALL have port flush, input, 1 bit: discard all held entries.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data/out_idx are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the output this cycle.
REQ-011 SHALL have port out_data, output, DATA bits: payload of the issued entry.
REQ-012 SHALL have port out_idx, output, $clog2(DEPTH) bits: slot index of the issued entry.
REQ-013 SHALL have port occ_vec, output, DEPTH bits: per-slot occupancy, active high, usable directly as the bit-vector select of a downstream priority selector.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1) bits: number of occupied slots.

Function
REQ-015 SHALL accept an entry on a rising edge where in_valid && in_ready, writing it into the lowest-indexed free slot and setting that slot's occ_vec bit.
REQ-016 SHALL drive in_ready = (count < DEPTH) && !flush, combinationally.
REQ-017 SHALL select the issue candidate as the lowest-indexed occupied slot; out_valid = |occ_vec in direct mode.
REQ-018 SHALL clear the issued slot's occ_vec bit on a rising edge where out_valid && out_ready.
REQ-019 SHALL compute the free slot from pre-edge occupancy, so a slot freed by issue is not reused in the same cycle.
REQ-020 SHALL update count by +1 on accept only, -1 on issue only, and leave it unchanged on simultaneous accept and issue.
REQ-021 SHALL hold out_data/out_idx stable while out_valid && !out_ready, except that a newly accepted entry in a lower-indexed slot takes priority on the next cycle.
REQ-022 SHALL, when flush is high at an edge, clear all occupancy, set count to 0, ignore any in_valid, and ignore out_ready for that edge.
REQ-023 SHALL drive out_data = 0 and out_idx = 0 whenever out_valid is 0.
REQ-024 SHALL have a latency from accept edge to out_valid of 1 cycle in direct mode, with an empty buffer.
REQ-025 SHALL, when full, keep in_ready = 0; an issue that edge makes in_ready = 1 in the following cycle.

Reset
REQ-026 SHALL, while reset is high, force occ_vec = 0, count = 0, out_valid = 0, out_data = 0 and out_idx = 0, independent of clk.
REQ-027 SHALL drive in_ready = 0 while reset is high, and resume normal operation on the first rising edge after reset deasserts.
REQ-028 SHALL discard all in-flight entries, including any output-register contents, on reset assertion mid-operation.

Configuration
REQ-029 SHALL, when ISSUE_BUF_OUTREG_EN is defined, insert a one-entry output register:
- the selected slot moves into the register when it is empty or being consumed, and the slot is freed on that move;
- out_* are driven from the register;
- count includes the register entry;
- occ_vec excludes the register entry;
- accept-to-out_valid latency is 2 cycles;
- flush and reset clear the register.
REQ-030 SHALL, without ISSUE_BUF_OUTREG_EN, drive out_* combinationally from the slot array per REQ-017.

Verification
REQ-031 SHALL cover the basic path: reset, in_data=0xA5 accepted, out_ready=1 -> out_valid next cycle (2 cycles with macro), out_data=0xA5, out_idx=0, count returns to 0.
REQ-032 SHALL cover fill: 8 accepts with out_ready=0 -> count=8, occ_vec=0xFF, in_ready=0, a 9th offer is not accepted.
REQ-033 SHALL cover simultaneous events: full buffer, in_valid=1 and out_ready=1 in the same cycle -> slot 0 issued, accept refused that cycle, count=7, then accept writes slot 0.
REQ-034 SHALL cover slot reuse: entries in slots 0..3, issue slot 0 while accepting 0x11 -> 0x11 goes to slot 4, count unchanged at 4.
REQ-035 SHALL cover flush: 5 entries held, flush=1 with in_valid=1 -> count=0, occ_vec=0, out_valid=0 next cycle, nothing accepted.
REQ-036 SHALL cover reset mid-operation: assert reset between clock edges with 3 entries held -> all outputs zero immediately, then normal accept after deassertion.
